// File: rtl/mul_pkg.sv
// Shared types and constants for the product accumulator: widths, FSM states,
// saturation limits, latched batch configuration and product extension helper.
package mul_pkg;

  localparam int PW   = 64;
  localparam int CNTW = 8;
  localparam int AW   = PW + CNTW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [PW-1:0] SMAX = {1'b0, {(PW-1){1'b1}}};
  localparam logic [PW-1:0] SMIN = {1'b1, {(PW-1){1'b0}}};
  localparam logic [PW-1:0] UMAX = {PW{1'b1}};

  typedef struct packed {
    logic [CNTW-1:0] len;
    logic            sgn;
    logic            sat;
  } cfg_t;

  function automatic logic [AW-1:0] ext_prod(input logic [PW-1:0] p, input logic sgn);
    return sgn ? {{CNTW{p[PW-1]}}, p} : {{CNTW{1'b0}}, p};
  endfunction

endpackage

// File: rtl/mul_acc_sat.sv
// Combinational range check of the wide accumulator and PW-bit result selection
// (saturate or wrap); zero latency, no flow control.
module mul_acc_sat
  import mul_pkg::*;
(
  input  logic [AW-1:0] acc,
  input  logic          signed_mode,
  input  logic          sat_en,
  output logic [PW-1:0] out_acc,
  output logic          ovf
);

  logic [AW-PW:0] top_bits;

  always_comb begin
    top_bits = acc[AW-1:PW-1];
    // A signed value fits in PW bits only when every guard bit copies the PW sign bit.
    ovf      = signed_mode ? !((&top_bits) || !(|top_bits)) : (|acc[AW-1:PW]);
    out_acc  = acc[PW-1:0];
    if (sat_en && ovf) begin
      out_acc = signed_mode ? (acc[AW-1] ? SMIN : SMAX) : UMAX;
    end
  end

endmodule

// File: rtl/mul_accumulator.sv
// Sums batch_len products into a guarded accumulator; result valid 1 cycle after the last accepted product.
// in_ready is high only while accumulating; the result holds in DONE until out_ready.
module mul_accumulator
  import mul_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [CNTW-1:0] batch_len,
  input  logic            signed_mode,
  input  logic            sat_en,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PW-1:0]   in_prod,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PW-1:0]   out_acc,
  output logic            out_ovf,
  output logic [CNTW-1:0] out_count,
  output logic            busy
);

  state_t          state, state_nxt;
  cfg_t            cfg;
  logic [AW-1:0]   acc, acc_sum;
  logic [CNTW-1:0] cnt;
  logic [PW-1:0]   sat_acc;
  logic            sat_ovf;
  logic            xfer, last;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  assign xfer    = in_valid & in_ready;
  assign last    = xfer && (cnt == cfg.len - 1'b1);
  assign acc_sum = acc + ext_prod(in_prod, cfg.sgn);

  // The result is judged on the sum including the final product, so it can be
  // registered on the same edge that accepts that product.
  mul_acc_sat u_sat (
    .acc         (acc_sum),
    .signed_mode (cfg.sgn),
    .sat_en      (cfg.sat),
    .out_acc     (sat_acc),
    .ovf         (sat_ovf)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (batch_len == '0) ? DONE : ACCUM;
      ACCUM:   if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg       <= '0;
      acc       <= '0;
      cnt       <= '0;
      out_acc   <= '0;
      out_ovf   <= 1'b0;
      out_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cfg       <= '{len: batch_len, sgn: signed_mode, sat: sat_en};
            acc       <= '0;
            cnt       <= '0;
            out_acc   <= '0;
            out_ovf   <= 1'b0;
            out_count <= '0;
          end
        end
        ACCUM: begin
          if (xfer) begin
            acc <= acc_sum;
            cnt <= cnt + 1'b1;
            if (last) begin
              out_acc   <= sat_acc;
              out_ovf   <= sat_ovf;
              out_count <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_acc   <= '0;
            out_ovf   <= 1'b0;
            out_count <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_accumulator.sv
// Randomized and directed stimulus for mul_accumulator, checked every cycle
// against an arithmetic reference model of batch summation.
module tb_mul_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  batch_len = '0;
  logic        signed_mode = 1'b0;
  logic        sat_en = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_prod = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_acc;
  logic        out_ovf;
  logic [7:0]  out_count;
  logic        busy;

  always #5 clk = ~clk;

  mul_accumulator dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .batch_len   (batch_len),
    .signed_mode (signed_mode),
    .sat_en      (sat_en),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_prod     (in_prod),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_acc     (out_acc),
    .out_ovf     (out_ovf),
    .out_count   (out_count),
    .busy        (busy)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: 0 idle, 1 collecting products, 2 result pending.
  localparam logic signed [79:0] SMAX_M = 80'sh0000_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [79:0] SMIN_M = 80'shFFFF_8000_0000_0000_0000;
  localparam logic signed [79:0] UMAX_M = 80'sh0000_FFFF_FFFF_FFFF_FFFF;
  localparam logic signed [79:0] TWO64  = 80'sh0001_0000_0000_0000_0000;

  int                    m_phase = 0;
  int                    m_len = 0;
  int                    m_cnt = 0;
  bit                    m_sgn = 1'b0;
  bit                    m_sat = 1'b0;
  logic signed [79:0]    m_sum = '0;

  function automatic logic [64:0] model_result();
    logic        ovf;
    logic [63:0] res;
    ovf = m_sgn ? (m_sum > SMAX_M || m_sum < SMIN_M) : (m_sum > UMAX_M);
    res = m_sum[63:0];
    if (ovf && m_sat) res = m_sgn ? ((m_sum < 0) ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF)
                                  : 64'hFFFF_FFFF_FFFF_FFFF;
    return {ovf, res};
  endfunction

  always @(negedge clk) begin
    logic [64:0]        r;
    logic signed [79:0] e;
    if (!rst) begin
      m_phase = 0;
      chk("reset_busy", busy, 0);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_acc", out_acc, 0);
      chk("reset_out_count", out_count, 0);
    end else begin
      chk("busy", busy, m_phase != 0);
      chk("in_ready", in_ready, m_phase == 1);
      chk("out_valid", out_valid, m_phase == 2);
      if (m_phase == 2) begin
        r = model_result();
        chk("out_acc", out_acc, r[63:0]);
        chk("out_ovf", out_ovf, r[64]);
        chk("out_count", out_count, m_cnt);
      end
      case (m_phase)
        0: if (start) begin
          m_len = batch_len;  m_sgn = signed_mode;  m_sat = sat_en;
          m_sum = '0;         m_cnt = 0;
          m_phase = (batch_len == 0) ? 2 : 1;
        end
        1: if (in_valid) begin
          e = {16'b0, in_prod};
          if (m_sgn && in_prod[63]) e = e - TWO64;
          m_sum = m_sum + e;
          m_cnt++;
          if (m_cnt == m_len) m_phase = 2;
        end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  logic [63:0] prods [256];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_batch(input int len, input bit sgn, input bit sat, input int max_stall,
                           input int hold, output logic [63:0] r_acc, output logic r_ovf,
                           output logic [7:0] r_cnt);
    int guard;
    start = 1'b1;  batch_len = len[7:0];  signed_mode = sgn;  sat_en = sat;
    tick();
    start = 1'b0;
    signed_mode = 1'($urandom);  sat_en = 1'($urandom);  batch_len = 8'($urandom);
    for (int i = 0; i < len; i++) begin
      int st = (max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0;
      in_valid = 1'b0;
      repeat (st) begin
        start = 1'($urandom);
        tick();
      end
      start = 1'b0;
      in_valid = 1'b1;
      in_prod = prods[i];
      guard = 0;
      while (!in_ready && guard < 10) begin
        tick();
        guard++;
      end
      if (!in_ready) chk("in_ready_timeout", in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    in_prod = {$urandom, $urandom};
    guard = 0;
    while (!out_valid && guard < 10) begin
      tick();
      guard++;
    end
    chk("result_latency", guard, 0);
    r_acc = out_acc;  r_ovf = out_ovf;  r_cnt = out_count;
    repeat (hold) begin
      start = 1'($urandom);  signed_mode = 1'($urandom);  batch_len = 8'($urandom);
      tick();
    end
    out_ready = 1'b1;
    start = 1'($urandom);
    tick();
    out_ready = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    logic [63:0] ra;
    logic        ro;
    logic [7:0]  rc;

    repeat (3) @(posedge clk);
    #1;
    chk("init_out_ovf", out_ovf, 0);
    chk("init_in_ready", in_ready, 0);
    rst = 1'b1;
    tick();

    prods[0] = 64'd5;  prods[1] = 64'd7;  prods[2] = 64'd11;
    run_batch(3, 0, 0, 0, 0, ra, ro, rc);
    chk("t1_acc", ra, 64'd23);  chk("t1_ovf", ro, 0);  chk("t1_count", rc, 3);

    prods[0] = 64'hFFFF_FFFF_FFFF_FFFA;  prods[1] = 64'd4;
    run_batch(2, 1, 0, 2, 1, ra, ro, rc);
    chk("t2_acc", ra, 64'hFFFF_FFFF_FFFF_FFFE);  chk("t2_ovf", ro, 0);

    prods[0] = 64'hFFFF_FFFF_0000_0001;  prods[1] = 64'hFFFF_FFFF_0000_0001;
    run_batch(2, 0, 1, 0, 0, ra, ro, rc);
    chk("t3_sat_acc", ra, 64'hFFFF_FFFF_FFFF_FFFF);  chk("t3_sat_ovf", ro, 1);
    run_batch(2, 0, 0, 0, 0, ra, ro, rc);
    chk("t3_wrap_acc", ra, 64'hFFFF_FFFE_0000_0002);  chk("t3_wrap_ovf", ro, 1);

    prods[0] = 64'h7FFF_FFFF_FFFF_FFFF;  prods[1] = 64'h7FFF_FFFF_FFFF_FFFF;
    run_batch(2, 1, 1, 0, 0, ra, ro, rc);
    chk("t4_acc", ra, 64'h7FFF_FFFF_FFFF_FFFF);  chk("t4_ovf", ro, 1);

    prods[0] = 64'h8000_0000_0000_0000;  prods[1] = 64'h8000_0000_0000_0000;
    run_batch(2, 1, 1, 0, 0, ra, ro, rc);
    chk("neg_sat_acc", ra, 64'h8000_0000_0000_0000);  chk("neg_sat_ovf", ro, 1);

    run_batch(0, 0, 0, 0, 5, ra, ro, rc);
    chk("t5_acc", ra, 0);  chk("t5_count", rc, 0);  chk("t5_ovf", ro, 0);

    for (int i = 0; i < 255; i++) prods[i] = 64'hFFFF_FFFF_FFFF_FFFF;
    run_batch(255, 0, 0, 0, 0, ra, ro, rc);
    chk("max_acc", ra, 64'hFFFF_FFFF_FFFF_FF01);  chk("max_ovf", ro, 1);  chk("max_count", rc, 255);

    // Abort a batch of four after two products.
    start = 1'b1;  batch_len = 8'd4;  signed_mode = 1'b0;  sat_en = 1'b0;
    tick();
    start = 1'b0;  in_valid = 1'b1;  in_prod = 64'd100;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("t6_busy", busy, 0);  chk("t6_in_ready", in_ready, 0);
    chk("t6_out_valid", out_valid, 0);  chk("t6_out_count", out_count, 0);
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    prods[0] = 64'd9;
    run_batch(1, 0, 0, 0, 0, ra, ro, rc);
    chk("t6_new_acc", ra, 64'd9);  chk("t6_new_count", rc, 1);

    for (int b = 0; b < 40; b++) begin
      int len = ($urandom_range(7, 0) == 0) ? int'($urandom_range(255, 13)) : int'($urandom_range(12, 0));
      for (int i = 0; i < len; i++) begin
        case ($urandom_range(3, 0))
          0:       prods[i] = 64'($urandom_range(1000, 0));
          1:       prods[i] = {$urandom, $urandom};
          2:       prods[i] = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(50, 0));
          default: prods[i] = ($urandom_range(1, 0) == 1)
                              ? 64'h8000_0000_0000_0000 + 64'($urandom_range(50, 0))
                              : 64'h7FFF_FFFF_FFFF_FFFF - 64'($urandom_range(50, 0));
        endcase
      end
      run_batch(len, 1'($urandom), 1'($urandom), 3, int'($urandom_range(3, 0)), ra, ro, rc);
    end

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
